// File: rtl/axis_traffic_chk.sv
// AXI-Stream sink that applies a rotating backpressure mask and checks for an incrementing data sequence.
// Optional protocol monitor (sticky proto_err) is built when AXIS_CHK_PROTO_EN is defined.
module axis_traffic_chk #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned CNT_WIDTH     = 32,
  parameter logic [7:0]  READY_PATTERN = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] axis_tdata,
  input  logic                  axis_tvalid,
  output logic                  axis_tready,
  input  logic                  enable,
  input  logic                  clear_stats,
  output logic                  locked,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  first_err_valid,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic [DATA_WIDTH-1:0] first_err_expected,
  output logic                  proto_err
);

  typedef enum logic {
    S_UNLOCKED = 1'b0,
    S_LOCKED   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            rot_q, rot_d;
  logic                  tready_q, tready_d;
  logic [DATA_WIDTH-1:0] expected_q, expected_d;
  logic [CNT_WIDTH-1:0]  beat_count_q, beat_count_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic                  locked_q, locked_d;
  logic                  first_err_valid_q, first_err_valid_d;
  logic [DATA_WIDTH-1:0] first_err_data_q, first_err_data_d;
  logic [DATA_WIDTH-1:0] first_err_expected_q, first_err_expected_d;

  logic beat_c;
  logic mismatch_c;
  logic proto_viol_c;

`ifdef AXIS_CHK_PROTO_EN
  logic                  stall_q, stall_d;
  logic [DATA_WIDTH-1:0] stall_data_q, stall_data_d;
  logic                  proto_err_q, proto_err_d;
`endif

  assign beat_c     = axis_tvalid & tready_q;
  assign mismatch_c = (axis_tdata != expected_q);

  // A stalled beat must stay valid with unchanged data until it is accepted.
`ifdef AXIS_CHK_PROTO_EN
  assign proto_viol_c = stall_q & (~axis_tvalid | (axis_tdata != stall_data_q));
`else
  assign proto_viol_c = 1'b0;
`endif

  always_comb begin
    state_d              = state_q;
    expected_d           = expected_q;
    beat_count_d         = beat_count_q;
    err_count_d          = err_count_q;
    locked_d             = locked_q;
    first_err_valid_d    = first_err_valid_q;
    first_err_data_d     = first_err_data_q;
    first_err_expected_d = first_err_expected_q;
`ifdef AXIS_CHK_PROTO_EN
    stall_d              = axis_tvalid & ~tready_q;
    stall_data_d         = axis_tdata;
    proto_err_d          = proto_err_q | proto_viol_c;
`endif

    // Backpressure keeps rotating independent of enable and clear_stats.
    rot_d    = {rot_q[6:0], rot_q[7]};
    tready_d = enable & rot_q[7];

    if (clear_stats) begin
      state_d              = S_UNLOCKED;
      beat_count_d         = '0;
      err_count_d          = '0;
      locked_d             = 1'b0;
      first_err_valid_d    = 1'b0;
      first_err_data_d     = '0;
      first_err_expected_d = '0;
`ifdef AXIS_CHK_PROTO_EN
      proto_err_d          = 1'b0;
`endif
    end else if (beat_c) begin
      expected_d = axis_tdata + DATA_WIDTH'(1);
      if (beat_count_q != '1) begin
        beat_count_d = beat_count_q + CNT_WIDTH'(1);
      end
      case (state_q)
        S_UNLOCKED: begin
          locked_d = 1'b1;
          state_d  = S_LOCKED;
        end
        S_LOCKED: begin
          if (mismatch_c) begin
            if (err_count_q != '1) begin
              err_count_d = err_count_q + CNT_WIDTH'(1);
            end
            if (!first_err_valid_q) begin
              first_err_valid_d    = 1'b1;
              first_err_data_d     = axis_tdata;
              first_err_expected_d = expected_q;
            end
          end
        end
        default: state_d = S_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= S_UNLOCKED;
      rot_q                <= READY_PATTERN;
      tready_q             <= 1'b0;
      expected_q           <= '0;
      beat_count_q         <= '0;
      err_count_q          <= '0;
      locked_q             <= 1'b0;
      first_err_valid_q    <= 1'b0;
      first_err_data_q     <= '0;
      first_err_expected_q <= '0;
    end else begin
      state_q              <= state_d;
      rot_q                <= rot_d;
      tready_q             <= tready_d;
      expected_q           <= expected_d;
      beat_count_q         <= beat_count_d;
      err_count_q          <= err_count_d;
      locked_q             <= locked_d;
      first_err_valid_q    <= first_err_valid_d;
      first_err_data_q     <= first_err_data_d;
      first_err_expected_q <= first_err_expected_d;
    end
  end

`ifdef AXIS_CHK_PROTO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q      <= 1'b0;
      stall_data_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      stall_q      <= stall_d;
      stall_data_q <= stall_data_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

  assign axis_tready        = tready_q;
  assign locked             = locked_q;
  assign beat_count         = beat_count_q;
  assign err_count          = err_count_q;
  assign first_err_valid    = first_err_valid_q;
  assign first_err_data     = first_err_data_q;
  assign first_err_expected = first_err_expected_q;

endmodule
